invaders_video: RTL and testbench
=================================

# invaders_video

Raster scan-out and interrupt generator for the Space Invaders system. Sits downstream of the i8080 and its shared RAM: reads the 7 KiB bitmap at 0x2400–0x3FFF through a read-only port, serialises it into a 1-bit pixel stream with sync and display-enable, and raises the two screen interrupts (RST 1 at mid-screen, RST 2 at the start of vertical blank). The interrupt vector is handed to the i8080 as an opcode on acknowledge.

## Interface
Parameters:
- H_ACTIVE, 256, visible pixels per line (multiple of 8, ≤256)
- H_TOTAL, 320, pixels per line including blank (multiple of 8)
- H_SYNC_START / H_SYNC_END, 272 / 296, hsync high for H_SYNC_START ≤ hcount < H_SYNC_END
- V_ACTIVE, 224, visible lines
- V_TOTAL, 262, total lines
- V_SYNC_START / V_SYNC_END, 240 / 243, vsync high for V_SYNC_START ≤ vcount < V_SYNC_END
- MID_LINE, 96, line that raises RST 1
- VRAM_BASE, 16'h2400, bitmap base address

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- pix_ce  in  1  pixel clock enable; all raster state advances only on edges with pix_ce=1
- vram_addr  out  16  RAM read address (registered)
- vram_data  in  8  RAM read data, ≤1 clk latency after vram_addr
- pixel  out  1  current pixel, 0 outside the active area
- de  out  1  hcount<H_ACTIVE && vcount<V_ACTIVE
- hsync, vsync  out  1  active-high sync
- hcount  out  9  current column; vcount  out  9  current line
- irq  out  1  interrupt request to the i8080
- irq_vector  out  8  RST opcode presented while irq=1
- inta  in  1  one-clk acknowledge from the i8080

## Operation
- Counters: hcount 0..H_TOTAL-1. At wrap, vcount increments 0..V_TOTAL-1 and then wraps to 0.
- Byte layout: line y, byte b (0..31) at VRAM_BASE + y*32 + b. Bit 0 is the leftmost pixel.
- Fetch: on the pix_ce edge leaving hcount[2:0]==5, vram_addr gets the address of the next group.
  - Within a line, the next group is byte hcount[7:3]+1.
  - At hcount = H_TOTAL-3, the next group is byte 0 of line (vcount+1) mod V_TOTAL.
- Load: on the pix_ce edge leaving hcount[2:0]==7, the shifter loads vram_data if the group about to start is active. Otherwise it loads 0.
- Shift: on every other pix_ce edge the shifter shifts right. pixel = shifter[0] & de.
- Blank-line fetches (line ≥ V_ACTIVE) are still issued; the returned data is discarded.
- Interrupts:
  - On the pix_ce edge entering (hcount=0, vcount=MID_LINE): irq←1, irq_vector←8'hCF.
  - On the pix_ce edge entering (hcount=0, vcount=V_ACTIVE): irq←1, irq_vector←8'hD7.
  - inta=1 with irq=1 clears irq on that edge. irq_vector holds its last value.
  - A new event while irq=1 overwrites irq_vector; only the latest vector is kept.
  - A new event in the same cycle as inta wins: irq stays 1 with the new vector.
  - inta is honoured regardless of pix_ce. inta while irq=0 is ignored.

## Timing
- Reset values: hcount=0, vcount=0, shifter=0, vram_addr=VRAM_BASE, pixel=0, irq=0, irq_vector=8'h00.
- de=1 at reset. hsync=0 and vsync=0 at reset with the default parameters.
- Because nothing was prefetched, the first 8 pixels of line 0 after reset are 0. Line 0 byte 1 is fetched normally.
- de, hsync, vsync and pixel are registered-state decodes with zero latency relative to hcount/vcount.
- Pixel pipeline: address change → data sampled 2 pix_ce edges later → pixel visible on the next cycle.
- irq rises in the same cycle that hcount/vcount show the trigger position.
- Reset mid-frame: all state is lost immediately, and scan-out restarts at line 0.

## Structure
- invaders_pkg holds RST1_OPCODE=8'hCF, RST2_OPCODE=8'hD7, VRAM_BASE, BYTES_PER_LINE=32, and the default geometry constants.
- Sub-module video_shifter: 8-bit load/shift-right register with ce, load, data_in and bit_out.
- Counters, fetch addressing, sync decode and the interrupt latch stay in invaders_video.

## Test plan
- Reset, RAM all 0xFF, pix_ce=1 → line 0 pixels 0–7 = 0, pixels 8–255 = 1, pixels 256–319 = 0. Line 1 pixels 0–255 = 1.
- RAM[0x2400+5*32+3]=8'b0000_0101, rest 0 → on line 5, pixel is 1 only at x=24 and x=26.
- Free run → irq rises at (0,96) with vector CF. inta 3 cycles later drops irq. irq rises at (0,224) with D7. Frame period = 320*262 pix_ce.
- Hold irq unacknowledged from line 96 through 224 → irq stays 1 and vector changes CF→D7 at (0,224).
- Assert inta on the exact cycle the V_ACTIVE event fires → irq=1, vector D7. inta with irq=0 → no change.
- pix_ce toggling 1-of-4 → counters advance once per 4 clk and pixel data is unchanged versus the pix_ce=1 run. rst_n pulsed mid-line 150 → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/invaders_pkg.sv
// Shared constants for the Invaders raster block: RST opcodes, bitmap base and default geometry.
package invaders_pkg;

  localparam logic [7:0]  RST1_OPCODE    = 8'hCF;
  localparam logic [7:0]  RST2_OPCODE    = 8'hD7;
  localparam logic [15:0] VRAM_BASE      = 16'h2400;
  localparam int          BYTES_PER_LINE = 32;

  localparam int H_ACTIVE_DEF     = 256;
  localparam int H_TOTAL_DEF      = 320;
  localparam int H_SYNC_START_DEF = 272;
  localparam int H_SYNC_END_DEF   = 296;
  localparam int V_ACTIVE_DEF     = 224;
  localparam int V_TOTAL_DEF      = 262;
  localparam int V_SYNC_START_DEF = 240;
  localparam int V_SYNC_END_DEF   = 243;
  localparam int MID_LINE_DEF     = 96;

  typedef logic [8:0] coord_t;

endpackage

// File: rtl/video_shifter.sv
// 8-bit pixel serialiser: parallel load, shift right, LSB is the current pixel.
module video_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       load,
  input  logic [7:0] data_in,
  output logic       bit_out
);

  logic [7:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (ce) begin
      if (load) sr <= data_in;
      else      sr <= {1'b0, sr[7:1]};
    end
  end

  assign bit_out = sr[0];

endmodule

// File: rtl/invaders_video.sv
// Raster counters, bitmap fetch, sync decode and RST 1 / RST 2 interrupt latch for the i8080.
module invaders_video
  import invaders_pkg::*;
#(
  parameter int          H_ACTIVE     = H_ACTIVE_DEF,
  parameter int          H_TOTAL      = H_TOTAL_DEF,
  parameter int          H_SYNC_START = H_SYNC_START_DEF,
  parameter int          H_SYNC_END   = H_SYNC_END_DEF,
  parameter int          V_ACTIVE     = V_ACTIVE_DEF,
  parameter int          V_TOTAL      = V_TOTAL_DEF,
  parameter int          V_SYNC_START = V_SYNC_START_DEF,
  parameter int          V_SYNC_END   = V_SYNC_END_DEF,
  parameter int          MID_LINE     = MID_LINE_DEF,
  parameter logic [15:0] VRAM_BASE    = invaders_pkg::VRAM_BASE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  output logic [15:0] vram_addr,
  input  logic [7:0]  vram_data,
  output logic        pixel,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [8:0]  hcount,
  output logic [8:0]  vcount,
  output logic        irq,
  output logic [7:0]  irq_vector,
  input  logic        inta
);

  localparam coord_t H_LAST       = 9'(H_TOTAL - 1);
  localparam coord_t H_FETCH_WRAP = 9'(H_TOTAL - 3);
  localparam coord_t V_LAST       = 9'(V_TOTAL - 1);

  function automatic logic [15:0] group_addr(input coord_t line, input logic [5:0] grp);
    return VRAM_BASE + 16'(line) * 16'(BYTES_PER_LINE) + 16'(grp);
  endfunction

  coord_t     h_next, v_next, v_inc;
  logic       next_active, line_end, shift_bit;
  logic       rst1_evt, rst2_evt;
  logic [7:0] load_data;

  always_comb begin
    v_inc  = (vcount == V_LAST) ? '0 : vcount + 9'd1;
    h_next = hcount + 9'd1;
    v_next = vcount;
    if (hcount == H_LAST) begin
      h_next = '0;
      v_next = v_inc;
    end
  end

  assign line_end    = pix_ce && (hcount == H_LAST);
  assign rst1_evt    = line_end && (v_inc == 9'(MID_LINE));
  assign rst2_evt    = line_end && (v_inc == 9'(V_ACTIVE));
  // The shifter is loaded for the group that starts on the next position.
  assign next_active = (h_next < 9'(H_ACTIVE)) && (v_next < 9'(V_ACTIVE));
  assign load_data   = next_active ? vram_data : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_ce) begin
      hcount <= h_next;
      vcount <= v_next;
    end
  end

  // Address goes out two pixel edges before the load so the RAM has a full clk to answer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_addr <= VRAM_BASE;
    end else if (pix_ce && hcount[2:0] == 3'd5) begin
      if (hcount == H_FETCH_WRAP) vram_addr <= group_addr(v_inc, 6'd0);
      else                        vram_addr <= group_addr(vcount, {1'b0, hcount[7:3]} + 6'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq        <= 1'b0;
      irq_vector <= 8'h00;
    end else if (rst1_evt) begin
      irq        <= 1'b1;
      irq_vector <= RST1_OPCODE;
    end else if (rst2_evt) begin
      irq        <= 1'b1;
      irq_vector <= RST2_OPCODE;
    end else if (inta && irq) begin
      irq        <= 1'b0;
    end
  end

  video_shifter u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce      (pix_ce),
    .load    (hcount[2:0] == 3'd7),
    .data_in (load_data),
    .bit_out (shift_bit)
  );

  assign de    = (hcount < 9'(H_ACTIVE)) && (vcount < 9'(V_ACTIVE));
  assign hsync = (hcount >= 9'(H_SYNC_START)) && (hcount < 9'(H_SYNC_END));
  assign vsync = (vcount >= 9'(V_SYNC_START)) && (vcount < 9'(V_SYNC_END));
  assign pixel = shift_bit & de;

endmodule

// File: tb/tb_invaders_video.sv
// Bench for invaders_video: frame-level model compared every cycle plus directed literal checks.
module tb_invaders_video;

  // Horizontal geometry stays at default; vertical is shortened so several frames fit a short run.
  localparam int HA = 256, HT = 320, HSS = 272, HSE = 296;
  localparam int VA = 32, VT = 40, VSS = 34, VSE = 36, MID = 12;
  localparam int BUDGET = 20000;

  logic        clk, rst_n, pix_ce, inta;
  logic [7:0]  vram_data;
  logic [15:0] vram_addr;
  logic        pixel, de, hsync, vsync, irq;
  logic [8:0]  hcount, vcount;
  logic [7:0]  irq_vector;

  invaders_video #(
    .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .MID_LINE(MID)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .vram_addr(vram_addr), .vram_data(vram_data),
    .pixel(pixel), .de(de), .hsync(hsync), .vsync(vsync), .hcount(hcount), .vcount(vcount),
    .irq(irq), .irq_vector(irq_vector), .inta(inta)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] mem [65536];
  always @(posedge clk) vram_data <= mem[vram_addr];

  int checks = 0, failures = 0, cyc = 0, div_cnt = 0;
  bit run = 0, div_mode = 0, timed_out = 0;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    div_cnt++;
    pix_ce = div_mode ? (div_cnt % 4 == 0) : 1'b1;
  end

  // Model: raster position, interrupt state and whether line 0 still lacks its prefetched byte.
  int m_h = 0, m_v = 0;
  bit m_irq = 0, m_prev = 0, m_fresh = 1;
  logic [7:0] m_vec = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_h = 0; m_v = 0; m_irq = 0; m_vec = 8'h00; m_fresh = 1;
    end else begin
      m_prev = m_irq;
      if (pix_ce) begin
        m_h++;
        if (m_h == HT) begin
          m_h = 0;
          m_v = (m_v + 1) % VT;
          if (m_v != 0) m_fresh = 0;
        end
      end
      if (pix_ce && m_h == 0 && m_v == MID)     begin m_irq = 1; m_vec = 8'hCF; end
      else if (pix_ce && m_h == 0 && m_v == VA) begin m_irq = 1; m_vec = 8'hD7; end
      else if (inta && m_prev)                  m_irq = 0;
    end
  end

  function automatic logic exp_pix(input int h, input int v, input bit fresh);
    logic [7:0] b;
    if (h >= HA || v >= VA) return 1'b0;
    if (fresh && v == 0 && h < 8) return 1'b0;
    b = mem[16'(32'h2400 + v * 32 + h / 8)];
    return b[h % 8];
  endfunction

  always @(negedge clk) begin
    if (run) begin
      logic [30:0] exp_v, act_v;
      exp_v = {exp_pix(m_h, m_v, m_fresh), (m_h < HA && m_v < VA), (m_h >= HSS && m_h < HSE),
               (m_v >= VSS && m_v < VSE), 9'(m_h), 9'(m_v), m_irq, m_vec};
      act_v = {pixel, de, hsync, vsync, hcount, vcount, irq, irq_vector};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL per_cycle t=%0t {pix,de,hs,vs,h,v,irq,vec} actual=%h required=%h", $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_pos(input int h, input int v);
    int n = 0;
    if (timed_out) return;
    while (!(hcount == 9'(h) && vcount == 9'(v)) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) begin
      timed_out = 1;
      checks++;
      failures++;
      $display("FAIL wait_pos timeout waiting for h=%0d v=%0d, at h=%0d v=%0d", h, v, hcount, vcount);
    end
  endtask

  task automatic pulse_inta();
    inta = 1'b1;
    @(negedge clk);
    inta = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hcount"}, 32'(hcount), 0);
    chk({tag, "_vcount"}, 32'(vcount), 0);
    chk({tag, "_vram_addr"}, 32'(vram_addr), 32'h2400);
    chk({tag, "_pixel"}, 32'(pixel), 0);
    chk({tag, "_de"}, 32'(de), 1);
    chk({tag, "_hsync"}, 32'(hsync), 0);
    chk({tag, "_vsync"}, 32'(vsync), 0);
    chk({tag, "_irq"}, 32'(irq), 0);
    chk({tag, "_vector"}, 32'(irq_vector), 0);
  endtask

  int t0, t1, c1, c2;

  initial begin
    rst_n = 1'b0; inta = 1'b0; pix_ce = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hFF;
    for (int b = 0; b < 32; b++) mem[16'h2400 + 5 * 32 + b] = 8'h00;
    mem[16'h2400 + 5 * 32 + 3] = 8'b0000_0101;

    repeat (3) @(negedge clk);
    run = 1;
    chk_reset_vals("reset");
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Frame 1: pixel pattern, fetch addresses, ack of RST 1, RST 2 rise, frame period.
    wait_pos(1, 0);   t0 = cyc;
    wait_pos(3, 0);   chk("l0_x3_unprefetched", 32'(pixel), 0);
    wait_pos(6, 0);   chk("l0_fetch_byte1", 32'(vram_addr), 32'h2401);
    wait_pos(8, 0);   chk("l0_x8", 32'(pixel), 1);
    wait_pos(255, 0); chk("l0_x255", 32'(pixel), 1);
    wait_pos(256, 0); chk("l0_x256_blank", 32'(pixel), 0);
    wait_pos(318, 0); chk("l0_fetch_wrap", 32'(vram_addr), 32'h2420);
    wait_pos(0, 1);   chk("l1_x0", 32'(pixel), 1);
    wait_pos(24, 5);  chk("l5_x24", 32'(pixel), 1);
    wait_pos(25, 5);  chk("l5_x25", 32'(pixel), 0);
    wait_pos(26, 5);  chk("l5_x26", 32'(pixel), 1);
    wait_pos(27, 5);  chk("l5_x27", 32'(pixel), 0);
    wait_pos(0, MID);
    chk("rst1_irq", 32'(irq), 1);
    chk("rst1_vec", 32'(irq_vector), 32'hCF);
    repeat (3) @(negedge clk);
    pulse_inta();
    chk("ack_irq", 32'(irq), 0);
    chk("ack_vec_held", 32'(irq_vector), 32'hCF);
    pulse_inta();
    chk("idle_inta_irq", 32'(irq), 0);
    chk("idle_inta_vec", 32'(irq_vector), 32'hCF);
    wait_pos(0, VA);
    chk("rst2_irq", 32'(irq), 1);
    chk("rst2_vec", 32'(irq_vector), 32'hD7);
    pulse_inta();
    chk("rst2_ack", 32'(irq), 0);
    wait_pos(1, 0);   t1 = cyc;
    chk("frame_period", 32'(t1 - t0), 32'(HT * VT));

    // Frame 2: RST 1 left pending; RST 2 arrives together with inta.
    wait_pos(0, MID);
    chk("f2_rst1_vec", 32'(irq_vector), 32'hCF);
    wait_pos(HT - 1, VA - 1);
    chk("f2_held_irq", 32'(irq), 1);
    chk("f2_held_vec", 32'(irq_vector), 32'hCF);
    pulse_inta();
    chk("f2_evt_pos", 32'({hcount, vcount}), 32'({9'd0, 9'(VA)}));
    chk("f2_evt_wins_irq", 32'(irq), 1);
    chk("f2_evt_wins_vec", 32'(irq_vector), 32'hD7);
    pulse_inta();
    chk("f2_final_ack", 32'(irq), 0);

    // Frame 3: asynchronous reset mid-line with an interrupt pending.
    wait_pos(0, MID);
    wait_pos(160, 20);
    chk("pre_reset_pixel", 32'(pixel), 1);
    chk("pre_reset_irq", 32'(irq), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midframe_reset");

    // Pixel enable at one edge in four after the reset.
    div_mode = 1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    wait_pos(3, 0);   chk("div_l0_x3", 32'(pixel), 0);
    wait_pos(8, 0);   chk("div_l0_x8", 32'(pixel), 1);
    wait_pos(11, 0);  c1 = cyc;
    wait_pos(12, 0);  c2 = cyc;
    chk("div_step_clks", 32'(c2 - c1), 4);
    wait_pos(24, 5);  chk("div_l5_x24", 32'(pixel), 1);
    wait_pos(25, 5);  chk("div_l5_x25", 32'(pixel), 0);
    wait_pos(26, 5);  chk("div_l5_x26", 32'(pixel), 1);

    run = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
